// File: rtl/eth_l2_rx_filter_if.sv
// ---------------------------------------------------------------------------
// eth_l2_rx_filter_if
// Byte-wide Avalon-ST link used on both sides of the L2 ingress filter.
//
// Signals:
//   valid          source -> sink  byte qualifier
//   data[7:0]      source -> sink  frame byte
//   channel        source -> sink  channel tag
//   error          source -> sink  per-byte error flag
//   startofpacket  source -> sink  first byte of a frame
//   endofpacket    source -> sink  last byte of a frame
//   ready          sink -> source  backpressure
//
// Modports: master drives the stream, slave consumes it.
// ---------------------------------------------------------------------------
interface eth_l2_rx_filter_if;
    logic       valid;
    logic [7:0] data;
    logic       channel;
    logic       error;
    logic       startofpacket;
    logic       endofpacket;
    logic       ready;

    modport master (
        output valid, data, channel, error, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  valid, data, channel, error, startofpacket, endofpacket,
        output ready
    );
endinterface

// File: rtl/eth_l2_rx_filter.sv
// ---------------------------------------------------------------------------
// eth_l2_rx_filter
// Layer-2 ingress filter. It buffers the 14-byte Ethernet header, checks the
// destination MAC and the EtherType against the configured rules, and then
// either replays the header and forwards the rest of the frame, or silently
// consumes the frame. Per-verdict saturating frame counters are exported.
//
// Ports:
//   Clk         in   rising-edge clock
//   Rst_n       in   synchronous active-low reset
//   filter_en   in   1 = apply rules, 0 = pass every non-runt frame
//   S_avalonST  slave  input byte stream from the MAC
//   M_avalonST  master filtered output byte stream
//   pass_cnt    out  frames forwarded (saturating)
//   drop_cnt    out  frames rejected by the rules (saturating)
//   runt_cnt    out  frames ending inside the header (saturating)
// ---------------------------------------------------------------------------
module eth_l2_rx_filter #(
    parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
    parameter bit          ALLOW_BCAST  = 1'b1,
    parameter logic [15:0] ETYPE_ALLOW0 = 16'h0800,
    parameter logic [15:0] ETYPE_ALLOW1 = 16'h0806
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      filter_en,
    eth_l2_rx_filter_if.slave         S_avalonST,
    eth_l2_rx_filter_if.master        M_avalonST,
    output logic [15:0]               pass_cnt,
    output logic [15:0]               drop_cnt,
    output logic [15:0]               runt_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DECIDE,
        FWD_HDR,
        PASS,
        DROP
    } state_t;

    localparam logic [3:0] LAST_HDR = 4'd13;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [7:0]  hdr_buf [0:13];
    logic [13:0] hdr_err_bits;
    logic        hdr_err;
    logic        chan_q;

    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_channel;
    logic        m_error;
    logic        m_sop;
    logic        m_eop;

    logic        s_xfer;
    logic        m_xfer;
    logic        runt_hit;
    logic        pass_hit;
    logic        drop_hit;

    logic [47:0] dst_mac;
    logic [15:0] etype;
    logic        dst_ok;
    logic        etype_ok;
    logic        accept;

    assign dst_mac  = {hdr_buf[0], hdr_buf[1], hdr_buf[2],
                       hdr_buf[3], hdr_buf[4], hdr_buf[5]};
    assign etype    = {hdr_buf[12], hdr_buf[13]};
    assign dst_ok   = (dst_mac == LOCAL_MAC) || (ALLOW_BCAST && (dst_mac == 48'hFFFF_FFFF_FFFF));
    assign etype_ok = (etype == ETYPE_ALLOW0) || (etype == ETYPE_ALLOW1);
    // With filtering disabled the verdict ignores addressing and header errors.
    assign accept   = !filter_en || (dst_ok && etype_ok && !hdr_err);

    assign s_xfer = S_avalonST.valid && s_ready;
    assign m_xfer = m_valid && M_avalonST.ready;

    assign S_avalonST.ready         = s_ready;
    assign M_avalonST.valid         = m_valid;
    assign M_avalonST.data          = m_data;
    assign M_avalonST.channel       = m_channel;
    assign M_avalonST.error         = m_error;
    assign M_avalonST.startofpacket = m_sop;
    assign M_avalonST.endofpacket   = m_eop;

    // Stream outputs. PASS is a pure combinational bridge, so everything is
    // gated by Rst_n to keep the outputs quiet during the reset cycle itself.
    always_comb begin
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = 8'h00;
        m_channel = 1'b0;
        m_error   = 1'b0;
        m_sop     = 1'b0;
        m_eop     = 1'b0;
        if (Rst_n) begin
            case (state)
                IDLE, HDR, DROP: begin
                    s_ready = 1'b1;
                end
                FWD_HDR: begin
                    m_valid   = 1'b1;
                    m_data    = hdr_buf[idx];
                    m_channel = chan_q;
                    m_error   = hdr_err_bits[idx];
                    m_sop     = (idx == 4'd0);
                end
                PASS: begin
                    m_valid   = S_avalonST.valid;
                    m_data    = S_avalonST.data;
                    m_channel = chan_q;
                    m_error   = S_avalonST.error;
                    m_eop     = S_avalonST.endofpacket;
                    s_ready   = M_avalonST.ready;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and the one-hot counter increment strobes.
    always_comb begin
        state_nxt = state;
        runt_hit  = 1'b0;
        pass_hit  = 1'b0;
        drop_hit  = 1'b0;
        case (state)
            IDLE: begin
                // A single-byte frame (sop and eop together) is already a runt.
                if (s_xfer && S_avalonST.startofpacket) begin
                    if (S_avalonST.endofpacket) begin
                        runt_hit = 1'b1;
                    end else begin
                        state_nxt = HDR;
                    end
                end
            end
            HDR: begin
                if (s_xfer) begin
                    if (S_avalonST.endofpacket) begin
                        runt_hit  = 1'b1;
                        state_nxt = IDLE;
                    end else if (idx == LAST_HDR) begin
                        state_nxt = DECIDE;
                    end
                end
            end
            DECIDE: begin
                state_nxt = accept ? FWD_HDR : DROP;
            end
            FWD_HDR: begin
                if (m_xfer && (idx == LAST_HDR)) begin
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (s_xfer && S_avalonST.endofpacket) begin
                    pass_hit  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (s_xfer && S_avalonST.endofpacket) begin
                    drop_hit  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Header capture, replay index and counters. idx is left at 0 after b13
    // so the replay starts from the first header byte.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            idx          <= 4'd0;
            hdr_err      <= 1'b0;
            hdr_err_bits <= '0;
            chan_q       <= 1'b0;
            pass_cnt     <= 16'h0000;
            drop_cnt     <= 16'h0000;
            runt_cnt     <= 16'h0000;
            for (int i = 0; i < 14; i++) begin
                hdr_buf[i] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (s_xfer && S_avalonST.startofpacket) begin
                        hdr_buf[0]      <= S_avalonST.data;
                        hdr_err_bits[0] <= S_avalonST.error;
                        hdr_err         <= S_avalonST.error;
                        chan_q          <= S_avalonST.channel;
                        idx             <= 4'd1;
                    end
                end
                HDR: begin
                    if (s_xfer) begin
                        hdr_buf[idx]      <= S_avalonST.data;
                        hdr_err_bits[idx] <= S_avalonST.error;
                        if (S_avalonST.error) begin
                            hdr_err <= 1'b1;
                        end
                        if (S_avalonST.endofpacket || (idx == LAST_HDR)) begin
                            idx <= 4'd0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                FWD_HDR: begin
                    if (m_xfer) begin
                        idx <= (idx == LAST_HDR) ? 4'd0 : idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase

            if (pass_hit && (pass_cnt != 16'hFFFF)) begin
                pass_cnt <= pass_cnt + 16'd1;
            end
            if (drop_hit && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (runt_hit && (runt_cnt != 16'hFFFF)) begin
                runt_cnt <= runt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_l2_rx_filter.sv
// ---------------------------------------------------------------------------
// tb_eth_l2_rx_filter
// Directed bench for the L2 ingress filter. Frames are driven byte by byte;
// every byte that should appear downstream is queued when it is driven, and a
// negedge monitor pops and compares each output transfer. A second instance
// built without broadcast acceptance covers the ALLOW_BCAST=0 case.
// ---------------------------------------------------------------------------
module tb_eth_l2_rx_filter;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
        logic       chan;
    } beat_t;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        filter_en;
    logic        m_ready;
    logic        sel;
    logic        drv_valid;
    logic [7:0]  drv_data;
    logic        drv_chan;
    logic        drv_err;
    logic        drv_sop;
    logic        drv_eop;
    logic        drv_ready;

    logic [15:0] pass0, drop0, runt0;
    logic [15:0] pass1, drop1, runt1;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_xfer_cyc = 0;
    int          b13_cyc = 0;
    bit          lat_check = 0;
    bit          toggle_en = 0;
    int          nb_valid_seen = 0;

    logic [7:0]  frm [$];
    beat_t       exp_q [$];

    eth_l2_rx_filter_if s0_if ();
    eth_l2_rx_filter_if m0_if ();
    eth_l2_rx_filter_if s1_if ();
    eth_l2_rx_filter_if m1_if ();

    // The shared driver is steered to one instance; the other sees an idle bus.
    assign s0_if.valid         = drv_valid & ~sel;
    assign s0_if.data          = sel ? 8'h00 : drv_data;
    assign s0_if.channel       = drv_chan & ~sel;
    assign s0_if.error         = drv_err & ~sel;
    assign s0_if.startofpacket = drv_sop & ~sel;
    assign s0_if.endofpacket   = drv_eop & ~sel;
    assign s1_if.valid         = drv_valid & sel;
    assign s1_if.data          = sel ? drv_data : 8'h00;
    assign s1_if.channel       = drv_chan & sel;
    assign s1_if.error         = drv_err & sel;
    assign s1_if.startofpacket = drv_sop & sel;
    assign s1_if.endofpacket   = drv_eop & sel;
    assign m0_if.ready         = m_ready;
    assign m1_if.ready         = m_ready;
    assign drv_ready           = sel ? s1_if.ready : s0_if.ready;

    eth_l2_rx_filter dut0 (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .filter_en  (filter_en),
        .S_avalonST (s0_if),
        .M_avalonST (m0_if),
        .pass_cnt   (pass0),
        .drop_cnt   (drop0),
        .runt_cnt   (runt0)
    );

    eth_l2_rx_filter #(.ALLOW_BCAST(1'b0)) dut1 (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .filter_en  (filter_en),
        .S_avalonST (s1_if),
        .M_avalonST (m1_if),
        .pass_cnt   (pass1),
        .drop_cnt   (drop1),
        .runt_cnt   (runt1)
    );

    // Free-running clock and a cycle counter used for latency measurement.
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream backpressure pattern 1,0,0,1 applied while toggle_en is set.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) begin
                m_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end
        end
    end

    // Safety net in case the DUT stops accepting input altogether.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Output monitor: compares every downstream transfer against the queue and
    // checks that a stalled beat is held unchanged into the next cycle.
    initial begin
        bit    prev_stall;
        beat_t prev_word;
        beat_t cur;
        beat_t exp;
        prev_stall = 0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 0;
            end else begin
                cur = {m0_if.data, m0_if.startofpacket, m0_if.endofpacket,
                       m0_if.error, m0_if.channel};
                if (prev_stall) begin
                    check_output("stall_hold", {19'd0, m0_if.valid, cur}, {19'd0, 1'b1, prev_word});
                end
                prev_stall = m0_if.valid && !m_ready;
                prev_word  = cur;
                if (m0_if.valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat actual=%0h required=none", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        check_output("out_beat", {20'd0, cur}, {20'd0, exp});
                        if (cur.sop && lat_check) begin
                            check_output("hdr_latency", cyc - b13_cyc, 2);
                            lat_check = 0;
                        end
                    end
                end
                if (m1_if.valid) begin
                    nb_valid_seen++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic make_frame(input logic [47:0] dst, input logic [15:0] et,
                              input int payload_len, input int seed);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'hA0 + i));
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int j = 0; j < payload_len; j++) frm.push_back(8'(seed + 7*j));
    endtask

    // Presents one byte and holds it until accepted, with a bounded wait.
    task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop,
                             input logic err, input logic chan, input bit chk_ready);
        int waited;
        drv_valid = 1'b1;
        drv_data  = d;
        drv_sop   = sop;
        drv_eop   = eop;
        drv_err   = err;
        drv_chan  = chan;
        waited    = 0;
        forever begin
            @(negedge clk);
            if (chk_ready) check_output("pass_ready_follow", {31'd0, drv_ready}, {31'd0, m_ready});
            if (drv_ready) break;
            waited++;
            if (waited > 200) begin
                errors++;
                $display("[TB] FAIL send_timeout actual=stalled required=accepted");
                break;
            end
        end
        last_xfer_cyc = cyc;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_sop   = 1'b0;
        drv_eop   = 1'b0;
        drv_err   = 1'b0;
    endtask

    // Sends the current frame (or its first n_send bytes) and queues the bytes
    // that should appear downstream when the frame is expected to pass.
    task automatic apply_stimulus(input bit expect_pass, input logic chan,
                                  input int err_idx, input int n_send, input bit chk_ready);
        int n;
        beat_t b;
        n = (n_send < 0) ? frm.size() : n_send;
        for (int i = 0; i < n; i++) begin
            b.data = frm[i];
            b.sop  = (i == 0);
            b.eop  = (i == frm.size() - 1);
            b.err  = (i == err_idx);
            b.chan = chan;
            if (expect_pass) exp_q.push_back(b);
            send_byte(b.data, b.sop, b.eop, b.err, chan, chk_ready && (i >= 15));
            if (i == 13) b13_cyc = last_xfer_cyc;
        end
    endtask

    task automatic check_counts(input string tag, input int p, input int d, input int r);
        check_output({tag, "_pass"}, {16'd0, pass0}, p);
        check_output({tag, "_drop"}, {16'd0, drop0}, d);
        check_output({tag, "_runt"}, {16'd0, runt0}, r);
    endtask

    initial begin
        rst_n     = 1'b0;
        filter_en = 1'b1;
        m_ready   = 1'b1;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_data  = 8'h00;
        drv_chan  = 1'b0;
        drv_err   = 1'b0;
        drv_sop   = 1'b0;
        drv_eop   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_outputs", {19'd0, m0_if.valid, m0_if.startofpacket, m0_if.endofpacket,
                     m0_if.error, m0_if.channel, m0_if.data}, 0);
        check_output("rst_s_ready", {31'd0, s0_if.ready}, 0);
        check_counts("rst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Unicast IPv4, 46-byte payload, with header latency check
        $display("[TB] unicast IPv4 frame");
        make_frame(LOCAL_MAC, 16'h0800, 46, 3);
        check_output("frame_len", frm.size(), 60);
        lat_check = 1;
        apply_stimulus(1, 1'b0, -1, -1, 0);
        idle(3);
        check_counts("t1", 1, 0, 0);
        check_output("lat_seen", {31'd0, lat_check}, 0);

        // Broadcast ARP on channel 1
        $display("[TB] broadcast ARP frame");
        make_frame(BCAST_MAC, 16'h0806, 46, 11);
        apply_stimulus(1, 1'b1, -1, -1, 0);
        idle(3);
        check_counts("t2", 2, 0, 0);

        // IPv6 to local MAC: dropped, then passed with filtering off
        $display("[TB] IPv6 frame filtered and unfiltered");
        make_frame(LOCAL_MAC, 16'h86DD, 20, 40);
        apply_stimulus(0, 1'b0, -1, -1, 0);
        idle(3);
        check_counts("t3", 2, 1, 0);
        filter_en = 1'b0;
        apply_stimulus(1, 1'b0, -1, -1, 0);
        idle(3);
        filter_en = 1'b1;
        check_counts("t4", 3, 1, 0);

        // Stray byte without sop in IDLE is discarded
        send_byte(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle(3);
        check_counts("stray", 3, 1, 0);

        // Runts: eop on b9, then eop on b13, then a good frame
        $display("[TB] runt frames");
        make_frame(LOCAL_MAC, 16'h0800, 0, 0);
        repeat (4) void'(frm.pop_back());
        apply_stimulus(0, 1'b0, -1, -1, 0);
        make_frame(LOCAL_MAC, 16'h0800, 0, 0);
        apply_stimulus(0, 1'b0, -1, -1, 0);
        make_frame(LOCAL_MAC, 16'h0800, 10, 77);
        apply_stimulus(1, 1'b0, -1, -1, 0);
        idle(3);
        check_counts("t6", 4, 1, 2);

        // Unknown unicast destination is dropped
        make_frame(OTHER_MAC, 16'h0800, 12, 5);
        apply_stimulus(0, 1'b0, -1, -1, 0);
        idle(3);
        check_counts("t7", 4, 2, 2);

        // Header error: dropped when filtering, forwarded with error when not
        $display("[TB] header error frames");
        make_frame(LOCAL_MAC, 16'h0800, 12, 9);
        apply_stimulus(0, 1'b0, 3, -1, 0);
        idle(3);
        check_counts("t8a", 4, 3, 2);
        filter_en = 1'b0;
        apply_stimulus(1, 1'b0, 3, -1, 0);
        idle(3);
        filter_en = 1'b1;
        check_counts("t8b", 5, 3, 2);

        // Output backpressure 1,0,0,1 through replay and payload
        $display("[TB] output backpressure");
        make_frame(LOCAL_MAC, 16'h0806, 30, 100);
        toggle_en = 1;
        apply_stimulus(1, 1'b1, -1, -1, 1);
        toggle_en = 0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        idle(3);
        check_counts("t9", 6, 3, 2);
        check_output("queue_drained", exp_q.size(), 0);

        // Reset at payload byte 20 of a passing frame
        $display("[TB] mid-frame reset");
        make_frame(LOCAL_MAC, 16'h0800, 46, 60);
        apply_stimulus(1, 1'b0, -1, 34, 0);
        drv_valid = 1'b1;
        drv_data  = frm[34];
        rst_n     = 1'b0;
        @(negedge clk);
        check_output("midrst_outputs", {19'd0, m0_if.valid, m0_if.startofpacket, m0_if.endofpacket,
                     m0_if.error, m0_if.channel, m0_if.data}, 0);
        check_output("midrst_s_ready", {31'd0, s0_if.ready}, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        drv_valid = 1'b0;
        check_counts("midrst", 0, 0, 0);
        for (int i = 34; i < 60; i++) begin
            send_byte(frm[i], 1'b0, i == 59, 1'b0, 1'b0, 0);
        end
        idle(3);
        check_counts("after_rst_tail", 0, 0, 0);
        make_frame(LOCAL_MAC, 16'h0800, 16, 23);
        apply_stimulus(1, 1'b0, -1, -1, 0);
        idle(3);
        check_counts("after_rst", 1, 0, 0);

        // Broadcast rejected by the instance without broadcast acceptance
        $display("[TB] broadcast with ALLOW_BCAST=0");
        sel = 1'b1;
        make_frame(BCAST_MAC, 16'h0806, 20, 1);
        apply_stimulus(0, 1'b0, -1, -1, 0);
        idle(3);
        sel = 1'b0;
        check_output("nb_valid", nb_valid_seen, 0);
        check_output("nb_drop", {16'd0, drop1}, 1);
        check_output("nb_pass", {16'd0, pass1}, 0);

        idle(5);
        check_output("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
